// File: rtl/reg_file_link.sv
// 32 x DATA_W register file: r0 hardwired to zero, three combinational read ports, link-register write port.
// Optional macro REGS_BYPASS_EN forwards same-cycle writes to rs_data/rt_data (never to dbg_data).
module reg_file_link #(
  parameter int unsigned DATA_W    = 32,
  parameter logic [4:0]  LINK_ADDR = 5'b11111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs_addr,
  output logic [DATA_W-1:0] rs_data,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rt_data,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              link_we,
  input  logic [DATA_W-1:0] link_data,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned NREGS = 32;

  logic [DATA_W-1:0] regs_q [NREGS-1:1];
  logic              link_wr_c;
  logic              gen_wr_c;

  // Link write beats a general write to the same index; writes to r0 are dropped.
  assign link_wr_c = link_we && (LINK_ADDR != 5'd0);
  assign gen_wr_c  = we && (wa != 5'd0) && !(link_wr_c && (wa == LINK_ADDR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (gen_wr_c) begin
        regs_q[wa] <= wd;
      end
      if (link_wr_c) begin
        regs_q[LINK_ADDR] <= link_data;
      end
    end
  end

`ifdef REGS_BYPASS_EN
  logic              byp_rs_c;
  logic              byp_rt_c;
  logic [DATA_W-1:0] byp_rs_data_c;
  logic [DATA_W-1:0] byp_rt_data_c;

  // Pending-write forwarding for the two datapath read ports.
  always_comb begin
    byp_rs_c      = 1'b0;
    byp_rt_c      = 1'b0;
    byp_rs_data_c = '0;
    byp_rt_data_c = '0;
    if (!rst) begin
      if (link_wr_c && (rs_addr == LINK_ADDR)) begin
        byp_rs_c      = 1'b1;
        byp_rs_data_c = link_data;
      end else if (gen_wr_c && (rs_addr == wa)) begin
        byp_rs_c      = 1'b1;
        byp_rs_data_c = wd;
      end
      if (link_wr_c && (rt_addr == LINK_ADDR)) begin
        byp_rt_c      = 1'b1;
        byp_rt_data_c = link_data;
      end else if (gen_wr_c && (rt_addr == wa)) begin
        byp_rt_c      = 1'b1;
        byp_rt_data_c = wd;
      end
    end
  end
`endif

  always_comb begin
    rs_data  = (rs_addr  == 5'd0) ? '0 : regs_q[rs_addr];
    rt_data  = (rt_addr  == 5'd0) ? '0 : regs_q[rt_addr];
    dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];
`ifdef REGS_BYPASS_EN
    if (byp_rs_c) begin
      rs_data = byp_rs_data_c;
    end
    if (byp_rt_c) begin
      rt_data = byp_rt_data_c;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file_link.sv
// Randomized self-checking bench for reg_file_link against an array-based register model.
// Honors REGS_BYPASS_EN when the same macro is defined for the bench.
module tb_reg_file_link;

  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [4:0]        rs_addr, rt_addr, wa, dbg_addr;
  logic [DATA_W-1:0] rs_data, rt_data, dbg_data, wd, link_data;
  logic              we, link_we;

  logic [DATA_W-1:0] model [32];
  int                n_tests = 0;
  int                n_fail  = 0;

  reg_file_link #(.DATA_W(DATA_W), .LINK_ADDR(5'd31)) dut (
    .clk(clk), .rst(rst),
    .rs_addr(rs_addr), .rs_data(rs_data),
    .rt_addr(rt_addr), .rt_data(rt_data),
    .we(we), .wa(wa), .wd(wd),
    .link_we(link_we), .link_data(link_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] stored(input logic [4:0] a);
    return (a == 5'd0) ? '0 : model[a];
  endfunction

  // Expected datapath read, including same-cycle forwarding in the bypass build.
  function automatic logic [DATA_W-1:0] exp_rd(input logic [4:0] a);
    logic [DATA_W-1:0] v;
    v = stored(a);
`ifdef REGS_BYPASS_EN
    if (!rst && a != 5'd0) begin
      if (link_we && a == 5'd31) v = link_data;
      else if (we && a == wa)    v = wd;
    end
`endif
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  // One rising edge; model commits the same writes the spec demands, link last so it wins.
  task automatic cycle();
    @(posedge clk);
    if (rst) clear_model();
    else begin
      if (we && wa != 5'd0) model[wa] = wd;
      if (link_we) model[31] = link_data;
    end
    #1;
  endtask

  task automatic idle();
    we = 1'b0; link_we = 1'b0; wa = '0; wd = '0; link_data = '0;
  endtask

  task automatic write(input logic [4:0] a, input logic [DATA_W-1:0] d);
    we = 1'b1; wa = a; wd = d;
    cycle();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rs_addr = '0; rt_addr = '0; dbg_addr = '0;
    clear_model();
    repeat (2) cycle();
    rst = 1'b0;
    #1;

    // Everything reads zero out of reset.
    for (int a = 0; a < 32; a += 7) begin
      rs_addr = 5'(a); rt_addr = 5'(a); dbg_addr = 5'(a);
      #1;
      check("reset_rs", rs_data, '0);
      check("reset_rt", rt_data, '0);
      check("reset_dbg", dbg_data, '0);
    end

    // Asynchronous reset clears r5 before the next edge.
    write(5'd5, 32'h1234);
    rs_addr = 5'd5;
    #1;
    check("r5_written", rs_data, 32'h1234);
    rst = 1'b1;
    #1;
    check("async_rst_rs5", rs_data, '0);
    clear_model();
    // A write presented during reset must not land.
    we = 1'b1; wa = 5'd3; wd = 32'hDEAD_BEEF;
    cycle();
    idle();
    dbg_addr = 5'd3;
    #1;
    check("rst_blocks_write", dbg_data, '0);
    rst = 1'b0;
    #1;

    write(5'd0, 32'hFFFF_FFFF);
    rs_addr = 5'd0;
    #1;
    check("r0_discard", rs_data, '0);

    we = 1'b1; wa = 5'd31; wd = 32'hAAAA_0000; link_we = 1'b1; link_data = 32'h0040_0008;
    cycle();
    idle();
    dbg_addr = 5'd31;
    #1;
    check("link_priority", dbg_data, 32'h0040_0008);

    we = 1'b1; wa = 5'd8; wd = 32'h11; link_we = 1'b1; link_data = 32'h0040_0010;
    cycle();
    idle();
    rs_addr = 5'd8; rt_addr = 5'd31;
    #1;
    check("dual_write_r8", rs_data, 32'h11);
    check("dual_write_r31", rt_data, 32'h0040_0010);

    write(5'd9, 32'h5);
    we = 1'b1; wa = 5'd9; wd = 32'h7; rs_addr = 5'd9; dbg_addr = 5'd9;
    #1;
`ifdef REGS_BYPASS_EN
    check("bypass_pre_edge", rs_data, 32'h7);
`else
    check("bypass_pre_edge", rs_data, 32'h5);
`endif
    check("dbg_no_bypass", dbg_data, 32'h5);
    cycle();
    idle();
    #1;
    check("r9_post_edge", rs_data, 32'h7);

    for (int i = 1; i < 32; i++) write(5'(i), DATA_W'(i));
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a);
      #1;
      check("dbg_sweep", dbg_data, DATA_W'(a));
    end

    // Random traffic: check all ports before and after each edge.
    for (int n = 0; n < 400; n++) begin
      we        = ($urandom_range(0, 2) != 0);
      link_we   = ($urandom_range(0, 3) == 0);
      wa        = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      wd        = $urandom;
      link_data = $urandom;
      rs_addr   = 5'($urandom_range(0, 31));
      rt_addr   = ($urandom_range(0, 3) == 0) ? rs_addr : 5'($urandom_range(0, 31));
      dbg_addr  = 5'($urandom_range(0, 31));
      #1;
      check("rand_rs_pre", rs_data, exp_rd(rs_addr));
      check("rand_rt_pre", rt_data, exp_rd(rt_addr));
      check("rand_dbg_pre", dbg_data, stored(dbg_addr));
      cycle();
      we = 1'b0; link_we = 1'b0;
      #1;
      check("rand_rs_post", rs_data, stored(rs_addr));
      check("rand_rt_post", rt_data, stored(rt_addr));
      check("rand_dbg_post", dbg_data, stored(dbg_addr));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_link.md
REG_FILE_LINK -- requirements
Module: reg_file_link

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 The block SHALL have parameter LINK_ADDR, default 5'b11111, link register index ($ra).

Ports (name, direction, width, meaning):
REQ-003 clk input 1: single clock; all state changes occur on its rising edge.
REQ-004 rst input 1: reset, asynchronous and active-high.
REQ-005 rs_addr input 5: read port A register index.
REQ-006 rs_data output DATA_W: read port A data.
REQ-007 rt_addr input 5: read port B register index.
REQ-008 rt_data output DATA_W: read port B data.
REQ-009 we input 1: general write enable.
REQ-010 wa input 5: general write index.
REQ-011 wd input DATA_W: general write data.
REQ-012 link_we input 1: link write enable; writes link_data to register LINK_ADDR.
REQ-013 link_data input DATA_W: return address, PC+4, supplied by the datapath.
REQ-014 dbg_addr input 5: debug/display read index.
REQ-015 dbg_data output DATA_W: debug read data.

Function
REQ-016 The storage SHALL be 32 registers of DATA_W bits; register 0 SHALL have no storage and SHALL always read 0.
REQ-017 Reads on all three ports SHALL be combinational from the addressed register, with zero-cycle latency.
REQ-018 On a rising clk edge with we=1 and wa!=0, register[wa] SHALL take wd; with wa=0 the write SHALL be discarded.
REQ-019 On a rising clk edge with link_we=1, register[LINK_ADDR] SHALL take link_data.
REQ-020 If link_we=1 and we=1 with wa=LINK_ADDR on the same edge, link_data SHALL win and wd SHALL be discarded.
REQ-021 If link_we=1 and we=1 with wa!=LINK_ADDR on the same edge, both writes SHALL complete on that edge.
REQ-022 With we=0 and link_we=0, no register SHALL change.
REQ-023 A value written on edge N SHALL be visible on all read ports immediately after edge N.
REQ-024 When both read ports address the same register, both SHALL return identical data.

Reset
REQ-025 While rst=1, all 31 stored registers SHALL be cleared to 0 asynchronously, independent of clk.
REQ-026 While rst=1, writes SHALL be ignored; rst asserted on the same edge as a write SHALL leave the target at 0.
REQ-027 After rst deasserts, the first rising edge SHALL accept writes normally.
REQ-028 Out of reset, rs_data, rt_data and dbg_data SHALL all read 0 for every address.

Configuration
REQ-029 Macro REGS_BYPASS_EN SHALL select write-through forwarding on rs_data and rt_data.
REQ-030 With REGS_BYPASS_EN defined, a read whose index matches a pending write in the current cycle (after the REQ-020 priority, nonzero index, rst=0) SHALL return the pending write data combinationally.
REQ-031 Without REGS_BYPASS_EN, reads SHALL return the stored value only; dbg_data SHALL never be bypassed in either build.

Verification
REQ-032 Pulse rst=1 mid-cycle after writing 0x1234 to r5 -> rs_data with rs_addr=5 reads 0 before the next clk edge.
REQ-033 we=1, wa=0, wd=0xFFFFFFFF, one edge -> rs_addr=0 reads 0.
REQ-034 we=1, wa=31, wd=0xAAAA0000, link_we=1, link_data=0x00400008, one edge -> r31=0x00400008.
REQ-035 we=1, wa=8, wd=0x11, link_we=1, link_data=0x00400010, one edge -> r8=0x11 and r31=0x00400010.
REQ-036 r9=0x5, then we=1, wa=9, wd=0x7 with rs_addr=9 before the edge -> rs_data=0x7 with REGS_BYPASS_EN defined, 0x5 without; 0x7 after the edge in both builds.
REQ-037 Write distinct values 1..31 to r1..r31, then sweep dbg_addr 0..31 -> dbg_data equals 0,1,...,31.
